// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, instruction
// field layout and the no-write-back codop.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // Field order matches the instruction word {codop, addrC, addrA, addrB}
  typedef struct packed {
    logic [3:0] codop;
    logic [3:0] addr_c;
    logic [3:0] addr_a;
    logic [3:0] addr_b;
  } instr_t;

  localparam logic [3:0] NOP_CODOP = 4'hF;

endpackage

// File: rtl/regfile_sequencer.sv
// Instruction sequencer: IDLE -> READ -> EXEC -> WB. It reads operands from the
// register file, runs the ALU handshake and issues a single-cycle write-back.
module regfile_sequencer
  import cpu_pkg::*;
#(
  parameter logic [3:0] NOWB_OP     = NOP_CODOP,
  parameter int         ALU_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [3:0]  rf_addr_a,
  output logic [3:0]  rf_addr_b,
  output logic [3:0]  rf_addr_c,
  output logic [3:0]  rf_codop,
  output logic        rf_we,
  output logic [15:0] rf_wdata,
  input  logic [15:0] rf_a,
  input  logic [15:0] rf_b,
  output logic        alu_start,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        err_timeout,
  output logic [7:0]  retired
);

  state_t     state;
  logic [7:0] timer;
  instr_t     in_w;

  assign in_w = instr;

  // All outputs are registered, so rf_we cannot glitch when reset hits mid-operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      instr_ready <= 1'b1;
      rf_addr_a   <= '0;
      rf_addr_b   <= '0;
      rf_addr_c   <= '0;
      rf_codop    <= '0;
      rf_we       <= 1'b0;
      rf_wdata    <= '0;
      alu_start   <= 1'b0;
      alu_op      <= '0;
      alu_x       <= '0;
      alu_y       <= '0;
      err_timeout <= 1'b0;
      retired     <= '0;
    end else begin
      alu_start <= 1'b0;
      rf_we     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            rf_codop    <= in_w.codop;
            alu_op      <= in_w.codop;
            rf_addr_a   <= in_w.addr_a;
            rf_addr_b   <= in_w.addr_b;
            rf_addr_c   <= in_w.addr_c;
            instr_ready <= 1'b0;
            state       <= S_READ;
          end
        end
        S_READ: begin
          alu_x     <= rf_a;
          alu_y     <= rf_b;
          alu_start <= 1'b1;
          timer     <= 8'd1;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          // A done in the start cycle takes priority over the timeout check
          if (alu_done) begin
            if (rf_codop == NOWB_OP) begin
              retired     <= retired + 8'd1;
              instr_ready <= 1'b1;
              state       <= S_IDLE;
            end else begin
              rf_wdata <= alu_result;
              rf_we    <= 1'b1;
              state    <= S_WB;
            end
          end else if (timer == 8'(ALU_TIMEOUT)) begin
            err_timeout <= 1'b1;
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        S_WB: begin
          retired     <= retired + 8'd1;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural register file and an
// adder ALU whose response latency can be set (or disabled entirely).
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  rf_addr_a, rf_addr_b, rf_addr_c, rf_codop, alu_op;
  logic        rf_we, alu_start, alu_done, err_timeout;
  logic [15:0] rf_wdata, rf_a, rf_b, alu_x, alu_y, alu_result;
  logic [7:0]  retired;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_addr_c(rf_addr_c), .rf_codop(rf_codop), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .rf_a(rf_a), .rf_b(rf_b), .alu_start(alu_start), .alu_op(alu_op),
    .alu_x(alu_x), .alu_y(alu_y), .alu_done(alu_done), .alu_result(alu_result),
    .err_timeout(err_timeout), .retired(retired)
  );

  // Register file model: combinational reads, write on the clock edge
  logic [15:0] rf [16];
  logic        rf_clr = 1'b0;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;
  int          wr_cnt;

  assign rf_a = rf[rf_addr_a];
  assign rf_b = rf[rf_addr_b];

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      wr_cnt <= 0;
    end else if (rf_we) begin
      rf[rf_addr_c] <= rf_wdata;
      wr_cnt <= wr_cnt + 1;
    end else if (pl_en) begin
      rf[pl_addr] <= pl_data;
    end
  end

  // Adder ALU: done alu_lat cycles after the start cycle (0 = same cycle)
  logic alu_en = 1'b1;
  int   alu_lat = 0;
  logic alu_busy;
  int   alu_cnt;

  assign alu_result = alu_x + alu_y;
  assign alu_done = alu_en && ((alu_start && alu_lat == 0) || (alu_busy && alu_cnt == alu_lat));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_busy <= 1'b0;
      alu_cnt  <= 0;
    end else if (alu_done || !alu_en) begin
      alu_busy <= 1'b0;
    end else if (alu_start) begin
      alu_busy <= 1'b1;
      alu_cnt  <= 1;
    end else if (alu_busy) begin
      alu_cnt <= alu_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic send(input logic [15:0] v);
    instr_valid = 1'b1; instr = v;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!instr_ready && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) chk("ready_bound", {31'd0, instr_ready}, 32'd1);
  endtask

  int n;
  int wr_snap;

  initial begin
    // Reset state
    rf_clr = 1'b1;
    tick();
    rf_clr = 1'b0;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_start", {31'd0, alu_start}, 32'd0);
    chk("rst_retired", {24'd0, retired}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    rst_n = 1'b1;
    preload(4'd1, 16'd5);
    preload(4'd3, 16'd7);

    // 16'h1213: R2 = R1 + R3, ALU responds one cycle after start
    alu_lat = 1;
    send(16'h1213);
    chk("t2_ready_busy", {31'd0, instr_ready}, 32'd0);
    chk("t2_addr_a", {28'd0, rf_addr_a}, 32'd1);
    chk("t2_addr_b", {28'd0, rf_addr_b}, 32'd3);
    tick();
    chk("t2_start", {31'd0, alu_start}, 32'd1);
    chk("t2_alu_x", {16'd0, alu_x}, 32'd5);
    chk("t2_alu_y", {16'd0, alu_y}, 32'd7);
    chk("t2_alu_op", {28'd0, alu_op}, 32'd1);
    tick();
    chk("t2_start_pulse", {31'd0, alu_start}, 32'd0);
    chk("t2_we_early", {31'd0, rf_we}, 32'd0);
    tick();
    chk("t2_we", {31'd0, rf_we}, 32'd1);
    chk("t2_addr_c", {28'd0, rf_addr_c}, 32'd2);
    chk("t2_wdata", {16'd0, rf_wdata}, 32'd12);
    tick();
    chk("t2_we_off", {31'd0, rf_we}, 32'd0);
    chk("t2_retired", {24'd0, retired}, 32'd1);
    chk("t2_ready", {31'd0, instr_ready}, 32'd1);
    chk("t2_r2", {16'd0, rf[2]}, 32'd12);

    // Back-to-back with instr_valid held high; 1-cycle ALU, minimum latency
    alu_lat = 0;
    instr_valid = 1'b1; instr = 16'h1211;
    tick();
    chk("t3_addr_a", {28'd0, rf_addr_a}, 32'd1);
    instr = 16'h1322;
    tick();
    chk("t3_x1", {16'd0, alu_x}, 32'd5);
    tick();
    chk("t3_we1", {31'd0, rf_we}, 32'd1);
    chk("t3_wdata1", {16'd0, rf_wdata}, 32'd10);
    chk("t3_ready_wb", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("t3_ready_idle", {31'd0, instr_ready}, 32'd1);
    chk("t3_retired1", {24'd0, retired}, 32'd2);
    tick();
    instr_valid = 1'b0;
    chk("t3_addr_a2", {28'd0, rf_addr_a}, 32'd2);
    tick();
    chk("t3_x2_raw", {16'd0, alu_x}, 32'd10);
    tick();
    chk("t3_wdata2", {16'd0, rf_wdata}, 32'd20);
    tick();
    chk("t3_r3", {16'd0, rf[3]}, 32'd20);
    chk("t3_retired2", {24'd0, retired}, 32'd3);
    chk("t3_wr_cnt", wr_cnt, 32'd3);

    // NOWB codop: executes, retires, never writes
    wr_snap = wr_cnt;
    send(16'hF123);
    tick();
    chk("t4_start", {31'd0, alu_start}, 32'd1);
    tick();
    chk("t4_we", {31'd0, rf_we}, 32'd0);
    chk("t4_ready", {31'd0, instr_ready}, 32'd1);
    chk("t4_retired", {24'd0, retired}, 32'd4);
    chk("t4_no_write", wr_cnt, wr_snap);
    chk("t4_r1", {16'd0, rf[1]}, 32'd5);

    // ALU never responds: READ + 15 EXEC cycles then abort
    alu_en = 1'b0;
    wr_snap = wr_cnt;
    send(16'h1111);
    wait_ready(n);
    chk("t5_cycles", n, 32'd16);
    chk("t5_err", {31'd0, err_timeout}, 32'd1);
    chk("t5_retired", {24'd0, retired}, 32'd4);
    chk("t5_no_write", wr_cnt, wr_snap);
    alu_en = 1'b1;
    send(16'h1411);
    wait_ready(n);
    chk("t5_next_r4", {16'd0, rf[4]}, 32'd10);
    chk("t5_next_retired", {24'd0, retired}, 32'd5);
    chk("t5_err_sticky", {31'd0, err_timeout}, 32'd1);

    // Retire counter wraps 255 -> 0
    for (int i = 0; i < 251; i++) begin
      send(16'hF000);
      wait_ready(n);
      if (i == 249) chk("t6_retired_255", {24'd0, retired}, 32'd255);
    end
    chk("t6_wrap", {24'd0, retired}, 32'd0);

    // Asynchronous reset in the middle of EXEC
    alu_en = 1'b0;
    send(16'h1511);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t1_ready", {31'd0, instr_ready}, 32'd1);
    chk("t1_we", {31'd0, rf_we}, 32'd0);
    chk("t1_retired", {24'd0, retired}, 32'd0);
    chk("t1_err", {31'd0, err_timeout}, 32'd0);
    chk("t1_start", {31'd0, alu_start}, 32'd0);
    tick();
    rst_n = 1'b1;
    alu_en = 1'b1;
    send(16'h1511);
    wait_ready(n);
    chk("t1_after_r5", {16'd0, rf[5]}, 32'd10);
    chk("t1_after_retired", {24'd0, retired}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
